// File: rtl/afifo_elastic_sender_if.sv
// Stream and FIFO-write-port bundle for afifo_elastic_sender.
// Ports (signals):
//   s_data/s_valid/s_ready      : wide input word stream (valid/ready)
//   f_data_out/f_write_en       : lane data and write strobe to the FIFO port
//   f_ready_in                  : FIFO port not-full
//   ovf_pending/stall_cycles    : overflow-slot status and stall counter
// master: the sender side; slave: the fabric/FIFO environment side.
interface afifo_elastic_sender_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RATIO = 2
);
    logic [RATIO*WIDTH-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic [WIDTH-1:0]       f_data_out;
    logic                   f_write_en;
    logic                   f_ready_in;
    logic                   ovf_pending;
    logic [15:0]            stall_cycles;

    modport master (
        input  s_data, s_valid, f_ready_in,
        output s_ready, f_data_out, f_write_en, ovf_pending, stall_cycles
    );

    modport slave (
        output s_data, s_valid, f_ready_in,
        input  s_ready, f_data_out, f_write_en, ovf_pending, stall_cycles
    );
endinterface

// File: rtl/afifo_elastic_sender.sv
// Write-side producer for the elastic asynchronous FIFO port.
// Serializes each RATIO*WIDTH input word into RATIO writes of WIDTH bits,
// using the port's single overflow slot: a write issued while the port is
// full parks in the slot, and no further write is issued until the slot
// drains on the first cycle the port reports ready.
// Ports:
//   write_clk   : clock
//   preset_full : asynchronous active-high reset
//   bus         : afifo_elastic_sender_if.master (stream in, FIFO port out,
//                 ovf_pending and stall_cycles status)
module afifo_elastic_sender #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RATIO = 2
) (
    input  logic                         write_clk,
    input  logic                         preset_full,
    afifo_elastic_sender_if.master       bus
);

    localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned WORD_W = RATIO * WIDTH;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic {
        SEND = 1'b0,
        OVF  = 1'b1
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] hold;
    logic              busy;
    logic [LANE_W-1:0] lane;
    logic [15:0]       stall_cycles;

    logic issue;
    logic last_lane;
    logic accept;

    // Output decode from registers only; f_ready_in never reaches an output.
    assign issue     = (state == SEND) & busy;
    assign last_lane = (lane == LAST_LANE);
    assign accept    = bus.s_valid & bus.s_ready;

    assign bus.s_ready      = ~preset_full & (~busy | ((state == SEND) & last_lane));
    assign bus.f_write_en   = issue;
    assign bus.f_data_out   = issue ? WIDTH'(hold >> (32'(lane) * WIDTH)) : '0;
    assign bus.ovf_pending  = (state == OVF);
    assign bus.stall_cycles = stall_cycles;

    // Lane sequencing, overflow tracking and word capture.
    always_ff @(posedge write_clk or posedge preset_full) begin
        if (preset_full) begin
            state        <= SEND;
            hold         <= '0;
            busy         <= 1'b0;
            lane         <= '0;
            stall_cycles <= '0;
        end else begin
            case (state)
                SEND: begin
                    // An issued write is always consumed (storage or slot),
                    // so the lane advances regardless of f_ready_in.
                    if (issue) begin
                        if (!bus.f_ready_in) begin
                            state <= OVF;
                        end
                        if (last_lane) begin
                            busy <= 1'b0;
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                OVF: begin
                    if (stall_cycles != STALL_MAX) begin
                        stall_cycles <= stall_cycles + 16'd1;
                    end
                    // Drain cycle: slot empties, no write issued this cycle.
                    if (bus.f_ready_in) begin
                        state <= SEND;
                    end
                end
                default: state <= SEND;
            endcase

            // Accept only happens when idle or on the last-lane write,
            // so it safely overrides the busy/lane updates above.
            if (accept) begin
                hold <= bus.s_data;
                busy <= 1'b1;
                lane <= '0;
            end
        end
    end

endmodule

// File: tb/tb_afifo_elastic_sender.sv
// Directed self-checking bench for afifo_elastic_sender (WIDTH=4, RATIO=2).
// A small FIFO-port model logs every write the port consumes and counts
// overflow-slot overwrites and writes issued during a drain cycle.
module tb_afifo_elastic_sender;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned RATIO = 2;

    logic write_clk;
    logic preset_full;

    afifo_elastic_sender_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

    afifo_elastic_sender #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .write_clk   (write_clk),
        .preset_full (preset_full),
        .bus         (bus)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Port model state.
    logic       slot_full = 1'b0;
    logic [3:0] wlog [$];
    int         n_overwrite = 0;
    int         n_drain_write = 0;

    // Port model, sampled mid-cycle when all signals are settled.
    always @(negedge write_clk) begin
        if (preset_full) begin
            slot_full     = 1'b0;
            n_overwrite   = 0;
            n_drain_write = 0;
            wlog.delete();
        end else if (slot_full && bus.f_ready_in) begin
            slot_full = 1'b0;
            if (bus.f_write_en) n_drain_write++;
        end else if (bus.f_write_en) begin
            wlog.push_back(bus.f_data_out);
            if (!bus.f_ready_in) begin
                if (slot_full) n_overwrite++;
                slot_full = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        bus.s_valid    = v;
        bus.s_data     = d;
        bus.f_ready_in = r;
    endtask

    task automatic expect_port(input string tag, input logic we, input logic [3:0] d,
                               input logic sr, input logic ovf);
        check({tag, "_we"},  32'(bus.f_write_en),  32'(we));
        check({tag, "_data"}, 32'(bus.f_data_out), 32'(d));
        check({tag, "_rdy"}, 32'(bus.s_ready),     32'(sr));
        check({tag, "_ovf"}, 32'(bus.ovf_pending), 32'(ovf));
    endtask

    // Compare the port model's write log against n nibbles (element i at exp[4*i +: 4]).
    task automatic check_log(input string tag, input int n, input logic [15:0] exp);
        logic [31:0] got;
        check({tag, "_nwrites"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEAD;
            check({tag, "_word"}, got, 32'(exp[4*i +: 4]));
        end
        check({tag, "_overwrite"}, 32'(n_overwrite), 32'd0);
        check({tag, "_drain_write"}, 32'(n_drain_write), 32'd0);
    endtask

    task automatic do_reset();
        preset_full = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        tick();
        preset_full = 1'b0;
        #1;
    endtask

    initial begin
        preset_full = 1'b1;
        drive(1'b0, 8'h00, 1'b1);

        // Reset values while held in reset, then s_ready after release.
        #3;
        expect_port("rst_hold", 1'b0, 4'h0, 1'b0, 1'b0);
        check("rst_hold_stall", 32'(bus.stall_cycles), 32'd0);
        tick();
        tick();
        preset_full = 1'b0;
        tick();
        expect_port("rst_rel", 1'b0, 4'h0, 1'b1, 1'b0);

        // Streaming 0xA5 then 0x3C back to back with the port always ready.
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        expect_port("str_c1", 1'b1, 4'h5, 1'b0, 1'b0);
        drive(1'b1, 8'h3C, 1'b1);
        tick();
        expect_port("str_c2", 1'b1, 4'hA, 1'b1, 1'b0);
        tick();
        expect_port("str_c3", 1'b1, 4'hC, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_port("str_c4", 1'b1, 4'h3, 1'b1, 1'b0);
        tick();
        expect_port("str_idle", 1'b0, 4'h0, 1'b1, 1'b0);
        check("str_stall", 32'(bus.stall_cycles), 32'd0);
        check_log("str", 4, 16'h3CA5);

        // Overflow on lane 0: three full cycles in OVF, then the drain.
        do_reset();
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        expect_port("ovf_c0", 1'b1, 4'h5, 1'b0, 1'b0);
        tick();
        expect_port("ovf_c1", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        expect_port("ovf_c2", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        expect_port("ovf_c3", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        expect_port("ovf_drain", 1'b0, 4'h0, 1'b0, 1'b1);
        check("ovf_drain_stall", 32'(bus.stall_cycles), 32'd3);
        tick();
        expect_port("ovf_resume", 1'b1, 4'hA, 1'b1, 1'b0);
        check("ovf_stall", 32'(bus.stall_cycles), 32'd4);
        tick();
        expect_port("ovf_idle", 1'b0, 4'h0, 1'b1, 1'b0);
        check_log("ovf", 2, 16'h00A5);

        // Last lane into overflow while a new word is offered.
        do_reset();
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        drive(1'b1, 8'h3C, 1'b1);
        expect_port("last_c1", 1'b1, 4'h5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h3C, 1'b0);
        expect_port("last_c2", 1'b1, 4'hA, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        expect_port("last_c3", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        expect_port("last_drain", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        expect_port("last_c5", 1'b1, 4'hC, 1'b0, 1'b0);
        tick();
        expect_port("last_c6", 1'b1, 4'h3, 1'b1, 1'b0);
        tick();
        expect_port("last_idle", 1'b0, 4'h0, 1'b1, 1'b0);
        check("last_stall", 32'(bus.stall_cycles), 32'd2);
        check_log("last", 4, 16'h3CA5);

        // Port full again right after every drain: one write per drain.
        do_reset();
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        expect_port("b2b_w0", 1'b1, 4'h5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        expect_port("b2b_d0", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h3C, 1'b0);
        expect_port("b2b_w1", 1'b1, 4'hA, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        expect_port("b2b_d1", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        expect_port("b2b_w2", 1'b1, 4'hC, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        expect_port("b2b_d2", 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        expect_port("b2b_w3", 1'b1, 4'h3, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        expect_port("b2b_d3", 1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        expect_port("b2b_idle", 1'b0, 4'h0, 1'b1, 1'b0);
        check("b2b_stall", 32'(bus.stall_cycles), 32'd4);
        check_log("b2b", 4, 16'h3CA5);

        // Asynchronous reset mid-word on lane 1; the word is dropped.
        do_reset();
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_port("mid_lane1", 1'b1, 4'hA, 1'b1, 1'b0);
        #2;
        preset_full = 1'b1;
        #1;
        expect_port("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0);
        check("mid_rst_stall", 32'(bus.stall_cycles), 32'd0);
        tick();
        preset_full = 1'b0;
        tick();
        expect_port("mid_rel", 1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_nowrite", 32'(bus.f_write_en), 32'd0);
        end
        check_log("mid", 0, 16'h0000);

        // Stall counter saturation and clear by reset.
        do_reset();
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        tick();
        repeat (70000) tick();
        check("sat_stall", 32'(bus.stall_cycles), 32'hFFFF);
        check("sat_ovf", 32'(bus.ovf_pending), 32'd1);
        check("sat_we", 32'(bus.f_write_en), 32'd0);
        repeat (5) tick();
        check("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);
        check_log("sat", 1, 16'h0005);
        preset_full = 1'b1;
        #1;
        check("sat_clr", 32'(bus.stall_cycles), 32'd0);
        check("sat_clr_ovf", 32'(bus.ovf_pending), 32'd0);
        tick();
        preset_full = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("sat_after", 32'(bus.stall_cycles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
